// File: rtl/reset_request_ctrl.sv
// Reset request stage: conditions the reset button, keyboard combos and register
// writes into fixed-width soft/hard/peripheral request pulses and records the cause.
module reset_request_ctrl #(
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_BITS   = 16,
    parameter int LONG_PRESS_BITS = 25,
    parameter int PULSE_HOLD      = 8
) (
    input  logic       clk_peripheral,
    input  logic       aresetn,
    input  logic       btn_resetn,
    input  logic       kbd_soft_req,
    input  logic       kbd_hard_req,
    input  logic       reg_wr,
    input  logic [1:0] reg_wdata,
    input  logic       peri_req,
    output logic       reset_soft,
    output logic       reset_hard,
    output logic       reset_peripheral,
    output logic [1:0] reset_cause,
    output logic       busy
);

    localparam int PW = $clog2(PULSE_HOLD + 1);
    localparam logic [DEBOUNCE_BITS-1:0]   DEB_MAX  = '1;
    localparam logic [LONG_PRESS_BITS-1:0] HOLD_MAX = '1;
    localparam logic [PW-1:0]              PULSE_LD = PW'(PULSE_HOLD);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESSED,
        ST_LONG
    } press_state_t;

    logic [SYNC_STAGES-1:0]     sync_q, sync_d;
    logic                       deb_q, deb_d;
    logic [DEBOUNCE_BITS-1:0]   deb_cnt_q, deb_cnt_d;
    press_state_t               state_q, state_d;
    logic [LONG_PRESS_BITS-1:0] hold_q, hold_d;
    logic [PW-1:0]              soft_cnt_q, soft_cnt_d;
    logic [PW-1:0]              hard_cnt_q, hard_cnt_d;
    logic [PW-1:0]              peri_cnt_q, peri_cnt_d;
    logic                       soft_q, soft_d;
    logic                       hard_q, hard_d;
    logic                       peri_q, peri_d;
    logic                       busy_q, busy_d;
    logic [1:0]                 cause_q, cause_d;

    logic btn_s;
    logic btn_soft, btn_hard;
    logic sw_soft, sw_hard, sw_event;
    logic soft_req, hard_req;

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], btn_resetn};
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (btn_s != deb_q) begin
            if (deb_cnt_q == DEB_MAX) begin
                deb_d = btn_s;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Release is checked before hold expiry so a release on the final count is still short.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        btn_soft = 1'b0;
        btn_hard = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (!deb_q) begin
                    state_d = ST_PRESSED;
                    hold_d  = '0;
                end
            end
            ST_PRESSED: begin
                if (deb_q) begin
                    state_d  = ST_RELEASED;
                    btn_soft = 1'b1;
                end else if (hold_q == HOLD_MAX) begin
                    state_d  = ST_LONG;
                    btn_hard = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_LONG: begin
                if (deb_q) begin
                    state_d = ST_RELEASED;
                end
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    always_comb begin
        sw_hard  = kbd_hard_req | (reg_wr & reg_wdata[1]);
        sw_soft  = kbd_soft_req | (reg_wr & (reg_wdata == 2'b01));
        sw_event = sw_hard | sw_soft;
        hard_req = btn_hard | sw_hard;
        soft_req = btn_soft | sw_soft;

        cause_d = cause_q;
        if (btn_hard) begin
            cause_d = 2'd2;
        end else if (btn_soft) begin
            cause_d = 2'd1;
        end else if (sw_event) begin
            cause_d = 2'd3;
        end
    end

    // Hard requests kill soft/peripheral pulses; downstream ORs hard into both anyway.
    always_comb begin
        hard_cnt_d = (hard_cnt_q != '0) ? hard_cnt_q - 1'b1 : '0;
        soft_cnt_d = (soft_cnt_q != '0) ? soft_cnt_q - 1'b1 : '0;
        peri_cnt_d = (peri_cnt_q != '0) ? peri_cnt_q - 1'b1 : '0;
        if (hard_req) begin
            hard_cnt_d = PULSE_LD;
            soft_cnt_d = '0;
            peri_cnt_d = '0;
        end else if (!hard_q) begin
            if (soft_req) begin
                soft_cnt_d = PULSE_LD;
            end
            if (peri_req) begin
                peri_cnt_d = PULSE_LD;
            end
        end
        soft_d = (soft_cnt_d != '0);
        hard_d = (hard_cnt_d != '0);
        peri_d = (peri_cnt_d != '0);
        busy_d = soft_d | hard_d | peri_d;
    end

    always_ff @(posedge clk_peripheral or negedge aresetn) begin
        if (!aresetn) begin
            sync_q     <= '1;
            deb_q      <= 1'b1;
            deb_cnt_q  <= '0;
            state_q    <= ST_RELEASED;
            hold_q     <= '0;
            soft_cnt_q <= '0;
            hard_cnt_q <= '0;
            peri_cnt_q <= '0;
            soft_q     <= 1'b0;
            hard_q     <= 1'b0;
            peri_q     <= 1'b0;
            busy_q     <= 1'b0;
            cause_q    <= 2'd0;
        end else begin
            sync_q     <= sync_d;
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
            soft_cnt_q <= soft_cnt_d;
            hard_cnt_q <= hard_cnt_d;
            peri_cnt_q <= peri_cnt_d;
            soft_q     <= soft_d;
            hard_q     <= hard_d;
            peri_q     <= peri_d;
            busy_q     <= busy_d;
            cause_q    <= cause_d;
        end
    end

    assign reset_soft       = soft_q;
    assign reset_hard       = hard_q;
    assign reset_peripheral = peri_q;
    assign busy             = busy_q;
    assign reset_cause      = cause_q;

endmodule

// File: tb/tb_reset_request_ctrl.sv
// Directed bench for reset_request_ctrl with a tiny debounce/hold configuration.
module tb_reset_request_ctrl;

    logic       clk_peripheral = 1'b0;
    logic       aresetn;
    logic       btn_resetn;
    logic       kbd_soft_req;
    logic       kbd_hard_req;
    logic       reg_wr;
    logic [1:0] reg_wdata;
    logic       peri_req;
    logic       reset_soft;
    logic       reset_hard;
    logic       reset_peripheral;
    logic [1:0] reset_cause;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int softHi, hardHi, periHi, busyBad;
    int softFirst, hardFirst, periFirst;
    int c0;

    reset_request_ctrl #(
        .SYNC_STAGES    (3),
        .DEBOUNCE_BITS  (2),
        .LONG_PRESS_BITS(4),
        .PULSE_HOLD     (4)
    ) dut (
        .clk_peripheral  (clk_peripheral),
        .aresetn         (aresetn),
        .btn_resetn      (btn_resetn),
        .kbd_soft_req    (kbd_soft_req),
        .kbd_hard_req    (kbd_hard_req),
        .reg_wr          (reg_wr),
        .reg_wdata       (reg_wdata),
        .peri_req        (peri_req),
        .reset_soft      (reset_soft),
        .reset_hard      (reset_hard),
        .reset_peripheral(reset_peripheral),
        .reset_cause     (reset_cause),
        .busy            (busy)
    );

    always #5 clk_peripheral = ~clk_peripheral;

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic btn, input logic kS, input logic kH,
                                 input logic wr, input logic [1:0] wd, input logic pr);
        btn_resetn   = btn;
        kbd_soft_req = kS;
        kbd_hard_req = kH;
        reg_wr       = wr;
        reg_wdata    = wd;
        peri_req     = pr;
    endtask

    task automatic clearStats();
        softHi = 0; hardHi = 0; periHi = 0; busyBad = 0;
        softFirst = -1; hardFirst = -1; periFirst = -1;
    endtask

    // Advance one edge, sample 1 time unit later, and accumulate pulse statistics.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_peripheral);
            #1;
            cyc++;
            if (reset_soft) begin
                softHi++;
                if (softFirst < 0) softFirst = cyc;
            end
            if (reset_hard) begin
                hardHi++;
                if (hardFirst < 0) hardFirst = cyc;
            end
            if (reset_peripheral) begin
                periHi++;
                if (periFirst < 0) periFirst = cyc;
            end
            if (busy != (reset_soft | reset_hard | reset_peripheral)) busyBad++;
        end
    endtask

    initial begin
        aresetn = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        clearStats();
        tick(3);
        checkOutput("rst_outs", {reset_soft, reset_hard, reset_peripheral, busy}, 0);
        checkOutput("rst_cause", reset_cause, 0);
        aresetn = 1'b1;
        tick(5);

        $display("[TB] bouncing button");
        clearStats();
        for (int k = 0; k < 30; k++) begin
            applyStimulus(!((k % 5) == 0 || (k % 5) == 1 || (k % 5) == 3),
                          1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick(30);
        checkOutput("bounce_pulses", softHi + hardHi + periHi, 0);
        checkOutput("bounce_cause", reset_cause, 0);

        $display("[TB] short press");
        clearStats();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick(15);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        c0 = cyc;
        tick(20);
        checkOutput("short_lat", softFirst - c0, 8);
        checkOutput("short_width", softHi, 4);
        checkOutput("short_nohard", hardHi, 0);
        checkOutput("short_cause", reset_cause, 1);
        checkOutput("short_busy", busyBad, 0);

        $display("[TB] long press");
        clearStats();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        c0 = cyc;
        tick(30);
        checkOutput("long_lat", hardFirst - c0, 24);
        checkOutput("long_width", hardHi, 4);
        checkOutput("long_cause", reset_cause, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick(20);
        checkOutput("long_nosoft", softHi, 0);
        checkOutput("long_busy", busyBad, 0);

        $display("[TB] register writes");
        clearStats();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick(3);
        checkOutput("wr00_pulses", softHi + hardHi + periHi, 0);
        checkOutput("wr00_cause", reset_cause, 2);
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        tick();
        checkOutput("wr11_hard", reset_hard, 1);
        checkOutput("wr11_cause", reset_cause, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick(8);
        checkOutput("wr11_lat", hardFirst - c0, 1);
        checkOutput("wr11_width", hardHi, 4);
        checkOutput("wr01_dropped", softHi, 0);

        $display("[TB] peripheral requests");
        clearStats();
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick(8);
        checkOutput("peri_lat", periFirst - c0, 1);
        checkOutput("peri_reload", periHi, 6);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        tick();
        checkOutput("kbd_hard_rise", reset_hard, 1);
        checkOutput("kbd_peri_clear", reset_peripheral, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick(8);
        checkOutput("kbd_peri_total", periHi, 7);
        checkOutput("kbd_hard_width", hardHi, 4);
        checkOutput("peri_busy", busyBad, 0);

        $display("[TB] reset mid pulse");
        clearStats();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick(25);
        checkOutput("mid_hard_on", reset_hard, 1);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("mid_outs", {reset_soft, reset_hard, reset_peripheral, busy}, 0);
        checkOutput("mid_cause", reset_cause, 0);
        tick(2);
        aresetn = 1'b1;
        c0 = cyc;
        clearStats();
        tick(35);
        checkOutput("rearm_lat", hardFirst - c0, 24);
        checkOutput("rearm_width", hardHi, 4);
        checkOutput("rearm_nosoft", softHi, 0);
        checkOutput("rearm_cause", reset_cause, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick(15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_request_ctrl.md
Name: reset_request_ctrl

Overview:
Upstream request stage for the system reset block. It turns the physical reset button, keyboard reset combos and software register writes into clean, fixed-width, active-high reset_soft / reset_hard / reset_peripheral request pulses in the clk_peripheral domain. A short button press gives a soft reset and a long press gives a hard reset. The block also records the cause of the last reset for software readback.

Parameters:
SYNC_STAGES, 3, synchroniser depth for btn_resetn (>=2)
DEBOUNCE_BITS, 16, debounce counter width; input must differ for 2^DEBOUNCE_BITS-1 consecutive cycles to register
LONG_PRESS_BITS, 25, hold counter width; press held 2^LONG_PRESS_BITS-1 debounced cycles = long press
PULSE_HOLD, 8, width in cycles of each output request pulse (>=1)

Ports:
clk_peripheral  in  1  single clock; all logic rising-edge
aresetn  in  1  asynchronous active-low reset; assertion clears all state immediately
btn_resetn  in  1  raw reset button, active low, asynchronous, bouncy
kbd_soft_req  in  1  synchronous 1-cycle soft-reset request from keyboard
kbd_hard_req  in  1  synchronous 1-cycle hard-reset request from keyboard
reg_wr  in  1  synchronous register write strobe
reg_wdata  in  2  bit1 = hard request, bit0 = soft request; sampled on reg_wr
peri_req  in  1  synchronous 1-cycle peripheral-only reset request
reset_soft  out  1  soft request pulse, active high
reset_hard  out  1  hard request pulse, active high
reset_peripheral  out  1  peripheral request pulse, active high
reset_cause  out  2  last cause: 0 none, 1 button short, 2 button long, 3 software/keyboard
busy  out  1  high while any output pulse is active

Behaviour:
- Reset values: all outputs 0. reset_cause = 0. Synchroniser flops, debounced state and press FSM = released (1). Hold and debounce counters = 0.
- Synchroniser: btn_resetn passes through SYNC_STAGES flops to give btn_s.
- Debounce: when btn_s == deb, cnt clears. Otherwise cnt increments. When cnt == 2^DEBOUNCE_BITS-1 and btn_s still differs, deb takes btn_s on the next edge and cnt clears.
- Press FSM, clocked on deb:
  - RELEASED: deb falls -> PRESSED, hold = 0.
  - PRESSED, deb high (release) -> RELEASED. Raise soft request, cause = 1.
  - PRESSED: hold increments each cycle. On hold == 2^LONG_PRESS_BITS-1 -> LONG. Raise hard request, cause = 2.
  - LONG: wait for deb high -> RELEASED. No further request. A release from LONG never generates a soft request.
- Software/keyboard:
  - reg_wr with wdata = 2'b10 or 2'b11 -> hard request.
  - reg_wr with wdata = 2'b01 -> soft request.
  - wdata = 2'b00 -> no action.
  - kbd_hard_req and kbd_soft_req act like hard and soft writes.
  - Each of these sets cause = 3.
- Same-cycle request merging:
  - Hard wins over soft from any source.
  - Among cause updates, the button cause has priority over software.
  - peri_req is independent and does not change cause.
- Pulse generators: one per output, each with its own down-counter.
  - A request in cycle t asserts the output from edge t+1 for exactly PULSE_HOLD cycles.
  - A new request while active reloads the counter, extending the pulse. There is no queueing.
- Hard suppression: a hard request clears any active soft or peripheral pulse on the same edge. While reset_hard is high, soft and peripheral requests are dropped, because the downstream stage ORs hard into both.
- busy = reset_soft | reset_hard | reset_peripheral, registered identically to the outputs.
- reset_cause persists until aresetn or the next cause. It is unaffected by the pulses it causes.
- aresetn mid-pulse or mid-press: everything clears. A button still held after release of aresetn must be re-debounced and produces a fresh press.
- Latency, button press edge to output: SYNC_STAGES + 2^DEBOUNCE_BITS-1 + 1 + 1 cycles after release (soft) or after hold expiry (hard).

Test Plan:
Test parameters: DEBOUNCE_BITS=2, LONG_PRESS_BITS=4, PULSE_HOLD=4.
1. Clean press, held 8 cycles after debounce, then released -> reset_soft high exactly 4 cycles; reset_hard stays 0; reset_cause=1; busy mirrors reset_soft.
2. Press held for 20 cycles -> reset_hard high 4 cycles after 15 debounced cycles; release gives no soft pulse; reset_cause=2.
3. btn_resetn toggling every 1-2 cycles for 30 cycles, then stable high -> no output pulse; reset_cause stays 0.
4. reg_wr with wdata=2'b11 -> reset_hard only, 4 cycles starting next edge; cause=3. Next, wdata=2'b01 while hard is active -> dropped; hard ends on schedule.
5. peri_req, then a second peri_req 2 cycles later -> reset_peripheral high for 6 cycles total (reload). Then kbd_hard_req during an active peripheral pulse -> peripheral cleared the same edge hard rises.
6. aresetn asserted mid reset_hard pulse with the button still held -> all outputs 0 immediately; cause=0. After aresetn release, a new hard pulse fires only after full re-debounce plus hold.
